// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer slice.
//   CTRL_STALL / CTRL_FLUSH : IDU control codes (any other code means run)
//   fetch_state_e           : sequencer state (RUN, STALL, HALT)
//   fetch_entry_t           : instruction buffer entry {pc, instr}
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 6;

  localparam logic [CTRL_W-1:0] CTRL_STALL = 6'b001001;
  localparam logic [CTRL_W-1:0] CTRL_FLUSH = 6'b001000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: IFU / IDU facing signals of the fetch sequencer.
//   master : the sequencer (drives pc and the instruction handshake)
//   slave  : the IFU/IDU environment (drives control, redirect, memory data, ready)
interface fetch_sequencer_if;

  logic [fetch_pkg::CTRL_W-1:0] control_signal;
  logic                         redirect_valid;
  logic [fetch_pkg::XLEN-1:0]   redirect_pc;
  logic [fetch_pkg::XLEN-1:0]   im_data;
  logic                         im_fetch_complete;
  logic [fetch_pkg::XLEN-1:0]   pc;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [fetch_pkg::XLEN-1:0]   instr_out;
  logic [fetch_pkg::XLEN-1:0]   instr_pc;

  modport master (
    input  control_signal, redirect_valid, redirect_pc,
    input  im_data, im_fetch_complete, instr_ready,
    output pc, instr_valid, instr_out, instr_pc
  );

  modport slave (
    output control_signal, redirect_valid, redirect_pc,
    output im_data, im_fetch_complete, instr_ready,
    input  pc, instr_valid, instr_out, instr_pc
  );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetch entries.
//   clk, rst      : clock, synchronous active-low reset
//   push/push_entry, pop : enqueue / dequeue requests (pop ignored when empty,
//                   push ignored when full unless a pop happens the same cycle)
//   clear         : empties the FIFO, dominates push and pop
//   head, full, empty : head entry and occupancy flags, all from registers
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 2;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full  = (cnt_q == 2'(DEPTH));
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state: pointer/count update, clear wins over everything
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the IFU program counter, buffers fetched words in a
// 2-entry FIFO towards the IDU and applies stall/flush codes and redirects.
//   clk, rst        : clock, synchronous active-low reset
//   bus (master)    : pc/im_data/im_fetch_complete to the IFU, control code,
//                     redirect and instr_valid/ready/out/pc handshake to the IDU
//   halted          : sequencer is in HALT
//   perf_fetched, perf_stalls : saturating counters, built only when
//                     FETCH_PERF_EN is defined, otherwise tied to 0
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_sequencer_if.master     bus,
  output logic                  halted,
  output logic [XLEN-1:0]       perf_fetched,
  output logic [XLEN-1:0]       perf_stalls
);

  localparam logic [XLEN-1:0] LAST_PC     = XLEN'(IMEM_DEPTH - 1);
  localparam logic [XLEN-1:0] DEPTH_PC    = XLEN'(IMEM_DEPTH);
  localparam logic [XLEN-1:0] RESET_PC_V  = XLEN'(RESET_PC);
  localparam fetch_state_e    RESET_STATE = (RESET_PC >= IMEM_DEPTH) ? HALT : RUN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;

  logic            buf_push, buf_pop, buf_clear;
  logic            buf_full, buf_empty;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_in;
  logic            deq;
  logic            is_stall, is_flush;

  assign deq      = !buf_empty && bus.instr_ready;
  assign is_stall = (bus.control_signal == CTRL_STALL);
  assign is_flush = (bus.control_signal == CTRL_FLUSH);
  assign buf_in   = '{pc: pc_q, instr: bus.im_data};

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .push_entry (buf_in),
    .pop        (buf_pop),
    .clear      (buf_clear),
    .head       (buf_head),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  // Sequencing: redirect > flush > stall > fetch; HALT only drains the buffer
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_push  = 1'b0;
    buf_pop   = deq;
    buf_clear = 1'b0;
    if (bus.redirect_valid) begin
      buf_clear = 1'b1;
      buf_pop   = 1'b0;
      pc_d      = bus.redirect_pc;
      state_d   = (bus.redirect_pc < DEPTH_PC) ? RUN : HALT;
    end else if (state_q == HALT) begin
      state_d = HALT;
    end else if (is_flush) begin
      // Replay from the oldest unconsumed instruction
      buf_clear = 1'b1;
      buf_pop   = 1'b0;
      if (!buf_empty) begin
        pc_d = buf_head.pc;
      end
      state_d = RUN;
    end else if (is_stall) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
      if (bus.im_fetch_complete && (!buf_full || deq)) begin
        buf_push = 1'b1;
        // Last word: hold pc and halt instead of wrapping
        if (pc_q == LAST_PC) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + XLEN'(1);
        end
      end
    end
    halted_d = (state_d == HALT);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RESET_STATE;
      pc_q     <= RESET_PC_V;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_valid = !buf_empty;
  assign bus.instr_out   = buf_head.instr;
  assign bus.instr_pc    = buf_head.pc;
  assign halted          = halted_q;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
  logic [XLEN-1:0] perf_stalls_q, perf_stalls_d;

  // Saturating event counters
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (buf_push && (perf_fetched_q != '1)) begin
      perf_fetched_d = perf_fetched_q + XLEN'(1);
    end
    if ((state_q == STALL) && (perf_stalls_q != '1)) begin
      perf_stalls_d = perf_stalls_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer.
// Instruction memory word at index p is (p+1)*11. A scoreboard queue holds the
// pcs expected at the IDU in delivery order; every accepted instruction is
// popped and compared. Directed checks cover reset, backpressure, stall,
// flush replay, redirect, halt at the top of memory and out-of-range redirect.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halted;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q [$];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .IMEM_DEPTH (1024),
    .RESET_PC   (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .halted       (halted),
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] p);
    return (p + 32'd1) * 32'd11;
  endfunction

  // Combinational instruction memory
  always_comb bus.im_data = word(bus.pc);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) exp_q.push_back(32'(p));
  endtask

  // Scoreboard: inputs are stable at the falling edge, so a handshake seen
  // here is the one taken on the next rising edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst && bus.instr_valid && bus.instr_ready && !bus.redirect_valid &&
        (bus.control_signal != CTRL_FLUSH)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", bus.instr_pc, e);
        check_eq("sb_data", bus.instr_out, word(e));
      end
    end
  end

  initial begin
    int guard;
    bus.control_signal    = '0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.im_fetch_complete = 1'b1;
    bus.instr_ready       = 1'b1;

    // Reset values
    step(3);
    check_eq("rst_pc", bus.pc, 32'd0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_out", bus.instr_out, 32'd0);
    check_eq("rst_ipc", bus.instr_pc, 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_perf_f", perf_fetched, 32'd0);
    check_eq("rst_perf_s", perf_stalls, 32'd0);

    // Streaming from reset: one instruction per cycle, 1 cycle latency
    push_range(0, 1023);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_eq("run_pc", bus.pc, 32'(i + 1));
      check_eq("run_out", bus.instr_out, word(32'(i)));
      check_eq("run_ipc", bus.instr_pc, 32'(i));
    end
`ifdef FETCH_PERF_EN
    check_eq("perf_fetched", perf_fetched, 32'd4);
`else
    check_eq("perf_fetched_off", perf_fetched, 32'd0);
`endif

    // Backpressure: buffer fills at 2 entries, head held stable
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_eq("bp_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("bp_ipc", bus.instr_pc, 32'd3);
      check_eq("bp_out", bus.instr_out, word(32'd3));
    end
    check_eq("bp_pc", bus.pc, 32'd5);
    bus.instr_ready = 1'b1;
    step(3);
    check_eq("pre_stall_pc", bus.pc, 32'd8);

    // Stall for 3 cycles: pc held, no enqueue, buffer drains
    bus.control_signal = CTRL_STALL;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("stall_pc", bus.pc, 32'd8);
    end
    check_eq("stall_drained", 32'(bus.instr_valid), 32'd0);
    bus.control_signal = 6'b000000;
    step(1);
    check_eq("resume_pc", bus.pc, 32'd9);
    check_eq("resume_ipc", bus.instr_pc, 32'd8);
`ifdef FETCH_PERF_EN
    check_eq("perf_stalls", perf_stalls, 32'd3);
`else
    check_eq("perf_stalls_off", perf_stalls, 32'd0);
`endif

    // Fetch not complete: pc holds
    bus.im_fetch_complete = 1'b0;
    step(1);
    check_eq("nofetch_pc", bus.pc, 32'd9);
    check_eq("nofetch_valid", 32'(bus.instr_valid), 32'd0);
    bus.im_fetch_complete = 1'b1;

    // Fill buffer: head 9, pc 11; then flush replays from head
    bus.instr_ready = 1'b0;
    step(2);
    check_eq("pre_flush_ipc", bus.instr_pc, 32'd9);
    check_eq("pre_flush_pc", bus.pc, 32'd11);
    bus.instr_ready    = 1'b1;
    bus.control_signal = CTRL_FLUSH;
    step(1);
    check_eq("flush_pc", bus.pc, 32'd9);
    check_eq("flush_valid", 32'(bus.instr_valid), 32'd0);
    bus.control_signal = 6'b000000;
    step(1);
    check_eq("replay_ipc", bus.instr_pc, 32'd9);
    check_eq("replay_out", bus.instr_out, word(32'd9));

    // Redirect to 20 with a simultaneous stall code
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd20;
    bus.control_signal = CTRL_STALL;
    exp_q.delete();
    push_range(20, 1023);
    step(1);
    check_eq("redir_pc", bus.pc, 32'd20);
    check_eq("redir_valid", 32'(bus.instr_valid), 32'd0);
    bus.redirect_valid = 1'b0;
    bus.control_signal = 6'b000000;
    step(1);
    check_eq("redir_first_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("redir_first_ipc", bus.instr_pc, 32'd20);
    check_eq("redir_pc_next", bus.pc, 32'd21);

    // Run to the top of memory
    guard = 0;
    while (!halted && guard < 1200) begin
      step(1);
      guard++;
    end
    check_eq("halt_reached", 32'(halted), 32'd1);
    check_eq("halt_pc", bus.pc, 32'd1023);
    step(1);
    check_eq("halt_drained", 32'(exp_q.size()), 32'd0);
    check_eq("halt_valid", 32'(bus.instr_valid), 32'd0);
    step(2);
    check_eq("halt_pc_held", bus.pc, 32'd1023);
    check_eq("halt_stays", 32'(halted), 32'd1);

    // Out-of-range redirect keeps HALT
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd4096;
    step(1);
    bus.redirect_valid = 1'b0;
    check_eq("oor_pc", bus.pc, 32'd4096);
    check_eq("oor_halted", 32'(halted), 32'd1);
    step(2);
    check_eq("oor_pc_held", bus.pc, 32'd4096);
    check_eq("oor_valid", 32'(bus.instr_valid), 32'd0);

    // Redirect to 0 leaves HALT
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd0;
    push_range(0, 7);
    step(1);
    bus.redirect_valid = 1'b0;
    check_eq("rerun_pc", bus.pc, 32'd0);
    check_eq("rerun_halted", 32'(halted), 32'd0);
    step(3);
    check_eq("rerun_pc3", bus.pc, 32'd3);
    check_eq("rerun_ipc", bus.instr_pc, 32'd2);
    check_eq("rerun_out", bus.instr_out, word(32'd2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
